// File: rtl/capture_pkg.sv
// Shared types and constants for the multichannel sample capture block.
// Contents:
//   capture_state_e - capture FSM states
//   MODE_SINGLE / MODE_CONT - capture mode encodings (latched on arm)
//   ch_width()      - width of a channel index (at least one bit)
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } capture_state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

  // A single channel still needs a one-bit channel field in the RAM word address.
  function automatic int ch_width(input int num_ch);
    if (num_ch <= 1) begin
      return 1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/multichannel_sample_capture_if.sv
// Random-access readout bus into the sample RAM.
// Signals:
//   rd_en    - read request (one word per cycle, back-to-back allowed)
//   rd_addr  - sample index to read
//   rd_ch    - channel to read
//   rd_data  - read data, registered, valid the cycle after rd_en
//   rd_valid - one-cycle pulse qualifying rd_data
// Modports: master = reader (Nios II / plotting side), slave = capture block.
interface multichannel_sample_capture_if
  import capture_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int CH_W     = ch_width(6),
  parameter int SAMPLE_W = 8
);

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CH_W-1:0]     rd_ch;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;

  modport master (
    output rd_en,
    output rd_addr,
    output rd_ch,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    input  rd_ch,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/capture_sample_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// A read of the word being written in the same cycle returns the old contents.
// Ports:
//   clk, rst_n     - clock, async active-low reset (read register only)
//   we/waddr/wdata - write port
//   re/raddr       - read request and address
//   rdata          - registered read data (holds when re is low)
module capture_sample_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [WORDS];
  logic [DATA_W-1:0] rdata_r;

  // Write port; the array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; non-blocking read yields old data on a same-word write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/multichannel_sample_capture.sv
// Multichannel sample capture: on each accepted strobe latches all channel
// codes, writes them one channel per cycle into a shared sample RAM at word
// address {sample index, channel}, and tracks write address and status.
// Ports:
//   clk_clk, reset_reset_n - clock, async active-low reset
//   channel_data           - packed channel codes, channel 0 in LSBs
//   sample_valid           - new-sample strobe
//   arm, mode, stop        - capture control (mode latched on accepted arm)
//   wr_addr                - index of next sample to be written
//   capture_done, busy     - DONE state / CAPTURE-or-WRITE state
//   wrapped, overrun       - sticky status, cleared by arm
//   rd_bus                 - random-access readout bus (slave side)
module multichannel_sample_capture
  import capture_pkg::*;
#(
  parameter int NUM_CH   = 6,
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 4096,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int CH_W     = ch_width(NUM_CH)
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   channel_data,
  input  logic                         sample_valid,
  input  logic                         arm,
  input  logic                         mode,
  input  logic                         stop,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         capture_done,
  output logic                         busy,
  output logic                         wrapped,
  output logic                         overrun,
  multichannel_sample_capture_if.slave rd_bus
);

  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  capture_state_e                state_r, state_nxt_s;
  logic                          mode_r, mode_nxt_s;
  logic [NUM_CH*SAMPLE_W-1:0]    hold_r, hold_nxt_s;
  logic [CH_W-1:0]               ch_r, ch_nxt_s;
  logic [ADDR_W-1:0]             wr_addr_r, wr_addr_nxt_s;
  logic                          wrapped_r, wrapped_nxt_s;
  logic                          overrun_r, overrun_nxt_s;
  logic                          stop_pend_r, stop_pend_nxt_s;
  logic                          busy_r;
  logic                          done_r;
  logic                          rd_valid_r;
  logic                          ram_we_s;
  logic [SAMPLE_W-1:0]           ram_wdata_s;
  logic [SAMPLE_W-1:0]           rd_data_s;

  // State and datapath registers; busy/done are registered from the next state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r     <= IDLE;
      mode_r      <= MODE_SINGLE;
      hold_r      <= {(NUM_CH*SAMPLE_W){1'b0}};
      ch_r        <= {CH_W{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
      wrapped_r   <= 1'b0;
      overrun_r   <= 1'b0;
      stop_pend_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mode_r      <= mode_nxt_s;
      hold_r      <= hold_nxt_s;
      ch_r        <= ch_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wrapped_r   <= wrapped_nxt_s;
      overrun_r   <= overrun_nxt_s;
      stop_pend_r <= stop_pend_nxt_s;
      busy_r      <= (state_nxt_s == CAPTURE) || (state_nxt_s == WRITE);
      done_r      <= (state_nxt_s == DONE);
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s     = state_r;
    mode_nxt_s      = mode_r;
    hold_nxt_s      = hold_r;
    ch_nxt_s        = ch_r;
    wr_addr_nxt_s   = wr_addr_r;
    wrapped_nxt_s   = wrapped_r;
    overrun_nxt_s   = overrun_r;
    stop_pend_nxt_s = stop_pend_r;

    case (state_r)
      IDLE, DONE: begin
        // arm outranks a simultaneous stop; strobes are ignored here.
        if (arm) begin
          state_nxt_s     = CAPTURE;
          mode_nxt_s      = mode;
          wr_addr_nxt_s   = {ADDR_W{1'b0}};
          wrapped_nxt_s   = 1'b0;
          overrun_nxt_s   = 1'b0;
          stop_pend_nxt_s = 1'b0;
          ch_nxt_s        = {CH_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end

      CAPTURE: begin
        // stop outranks a simultaneous strobe, and that strobe is not an overrun.
        if (stop) begin
          state_nxt_s = DONE;
        end else if (sample_valid) begin
          hold_nxt_s      = channel_data;
          ch_nxt_s        = {CH_W{1'b0}};
          stop_pend_nxt_s = 1'b0;
          state_nxt_s     = WRITE;
        end else begin
          state_nxt_s = CAPTURE;
        end
      end

      WRITE: begin
        if (sample_valid) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_r;
        end

        if (ch_r == LAST_CH) begin
          ch_nxt_s        = {CH_W{1'b0}};
          stop_pend_nxt_s = 1'b0;
          if ((mode_r == MODE_SINGLE) && (wr_addr_r == ADDR_MAX)) begin
            // Buffer full: wr_addr parks on the last index.
            state_nxt_s = DONE;
          end else begin
            wr_addr_nxt_s = wr_addr_r + ADDR_W'(1);
            if ((mode_r == MODE_CONT) && (wr_addr_r == ADDR_MAX)) begin
              wrapped_nxt_s = 1'b1;
            end else begin
              wrapped_nxt_s = wrapped_r;
            end
            // A stop arriving on the final channel cycle also ends the capture.
            if (stop_pend_r || stop) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = CAPTURE;
            end
          end
        end else begin
          ch_nxt_s = ch_r + CH_W'(1);
          if (stop) begin
            stop_pend_nxt_s = 1'b1;
          end else begin
            stop_pend_nxt_s = stop_pend_r;
          end
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign ram_we_s    = (state_r == WRITE);
  assign ram_wdata_s = hold_r[ch_r*SAMPLE_W +: SAMPLE_W];

  capture_sample_ram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (ADDR_W + CH_W)
  ) u_ram (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .we    (ram_we_s),
    .waddr ({wr_addr_r, ch_r}),
    .wdata (ram_wdata_s),
    .re    (rd_bus.rd_en),
    .raddr ({rd_bus.rd_addr, rd_bus.rd_ch}),
    .rdata (rd_data_s)
  );

  // Read-valid pulse aligned with the registered RAM output.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_bus.rd_en;
    end
  end

  assign rd_bus.rd_data  = rd_data_s;
  assign rd_bus.rd_valid = rd_valid_r;
  assign wr_addr         = wr_addr_r;
  assign capture_done    = done_r;
  assign busy            = busy_r;
  assign wrapped         = wrapped_r;
  assign overrun         = overrun_r;

endmodule

// File: tb/tb_multichannel_sample_capture.sv
// Self-checking bench for multichannel_sample_capture (NUM_CH=6, SAMPLE_W=8, DEPTH=16).
// Expected RAM contents are tracked in exp_mem as samples are driven; each read
// pushes its expected word to exp_q, popped and compared when rd_valid arrives.
module tb_multichannel_sample_capture;

  localparam int NUM_CH   = 6;
  localparam int SAMPLE_W = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int CH_W     = 3;

  logic                       clk_clk       = 1'b0;
  logic                       reset_reset_n = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] channel_data  = '0;
  logic                       sample_valid  = 1'b0;
  logic                       arm           = 1'b0;
  logic                       mode          = 1'b0;
  logic                       stop          = 1'b0;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       capture_done;
  logic                       busy;
  logic                       wrapped;
  logic                       overrun;

  multichannel_sample_capture_if #(
    .ADDR_W(ADDR_W), .CH_W(CH_W), .SAMPLE_W(SAMPLE_W)
  ) rd_bus ();

  multichannel_sample_capture #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .channel_data  (channel_data),
    .sample_valid  (sample_valid),
    .arm           (arm),
    .mode          (mode),
    .stop          (stop),
    .wr_addr       (wr_addr),
    .capture_done  (capture_done),
    .busy          (busy),
    .wrapped       (wrapped),
    .overrun       (overrun),
    .rd_bus        (rd_bus)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [SAMPLE_W-1:0] exp_mem [DEPTH][NUM_CH];
  logic [SAMPLE_W-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  function automatic logic [NUM_CH*SAMPLE_W-1:0] pat(input logic [7:0] base);
    logic [NUM_CH*SAMPLE_W-1:0] d;
    for (int k = 0; k < NUM_CH; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic do_arm(input logic m);
    arm = 1'b1; mode = m;
    tick();
    arm = 1'b0;
  endtask

  // One-cycle strobe; idx >= 0 records the sample as expected RAM contents.
  task automatic put_sample(input int idx, input logic [NUM_CH*SAMPLE_W-1:0] d);
    channel_data = d; sample_valid = 1'b1;
    if (idx >= 0) for (int k = 0; k < NUM_CH; k++) exp_mem[idx][k] = d[k*8 +: 8];
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_req(input int a, input int c);
    rd_bus.rd_en   = 1'b1;
    rd_bus.rd_addr = ADDR_W'(a);
    rd_bus.rd_ch   = CH_W'(c);
    exp_q.push_back(exp_mem[a][c]);
  endtask

  task automatic test_reset();
    logic [16:0] st;
    reset_reset_n = 1'b0;
    repeat (3) tick();
    st = {wr_addr, capture_done, busy, wrapped, overrun, rd_bus.rd_data, rd_bus.rd_valid};
    n_cmp++;
    if (st !== 17'd0) begin
      n_fail++; $display("FAIL reset_values: got %h want 00000", st);
    end
    reset_reset_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || capture_done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, capture_done);
    end
  endtask

  task automatic test_single_fill();
    int cnt;
    int ra [5] = '{5, 0, 15, 7, 5};
    int rc [5] = '{3, 0, 5, 2, 3};
    logic [7:0] ev;
    do_arm(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || wr_addr !== 4'd0) begin
      n_fail++; $display("FAIL fill_arm: busy=%b wr_addr=%0d want 1/0", busy, wr_addr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      put_sample(i, pat(8'(16 * i)));
      if (i < DEPTH - 1) repeat (7) tick();
    end
    cnt = 1;
    while (capture_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != 7) begin
      n_fail++; $display("FAIL fill_done_latency: got %0d cycles want 7", cnt);
    end
    n_cmp++;
    if (wr_addr !== 4'd15 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL fill_status: wr_addr=%0d busy=%b ovr=%b want 15/0/0", wr_addr, busy, overrun);
    end
    // Back-to-back reads, the first is (i=5, ch=3).
    for (int j = 0; j < 5; j++) begin
      read_req(ra[j], rc[j]);
      tick();
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== ev) begin
        n_fail++; $display("FAIL fill_read(%0d,%0d): valid=%b data=%h want 1/%h", ra[j], rc[j], rd_bus.rd_valid, rd_bus.rd_data, ev);
      end
    end
    n_cmp++;
    if (exp_mem[5][3] !== 8'h53) begin
      n_fail++; $display("FAIL fill_pattern: model %h want 53", exp_mem[5][3]);
    end
    rd_bus.rd_en = 1'b0;
    tick();
    n_cmp++;
    if (rd_bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_valid_pulse: got %b want 0", rd_bus.rd_valid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] ev;
    do_arm(1'b0);
    put_sample(0, pat(8'hA0));
    repeat (2) tick();
    put_sample(-1, pat(8'hC0));
    repeat (3) tick();
    n_cmp++;
    if (wr_addr !== 4'd1 || overrun !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL overrun_status: wr_addr=%0d ovr=%b busy=%b want 1/1/1", wr_addr, overrun, busy);
    end
    for (int j = 0; j < 7; j++) begin
      if (j < 6) read_req(0, j); else read_req(1, 0);
      tick();
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== ev) begin
        n_fail++; $display("FAIL overrun_read%0d: valid=%b data=%h want 1/%h", j, rd_bus.rd_valid, rd_bus.rd_data, ev);
      end
    end
    rd_bus.rd_en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (capture_done !== 1'b1 || wr_addr !== 4'd1) begin
      n_fail++; $display("FAIL stop_in_capture: done=%b wr_addr=%0d want 1/1", capture_done, wr_addr);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] ev;
    do_arm(1'b1);
    for (int s = 0; s < 20; s++) begin
      if (s == 15) begin
        n_cmp++;
        if (wrapped !== 1'b0 || wr_addr !== 4'd15) begin
          n_fail++; $display("FAIL cont_prewrap: wrapped=%b wr_addr=%0d want 0/15", wrapped, wr_addr);
        end
      end
      put_sample(s % DEPTH, pat(8'(8 * s)));
      repeat (7) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (wrapped !== 1'b1 || wr_addr !== 4'd4 || capture_done !== 1'b1) begin
      n_fail++; $display("FAIL cont_stop: wrapped=%b wr_addr=%0d done=%b want 1/4/1", wrapped, wr_addr, capture_done);
    end
    for (int j = 0; j < 7; j++) begin
      if (j < 6) read_req(2, j); else read_req(4, 0);
      tick();
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== ev) begin
        n_fail++; $display("FAIL cont_read%0d: valid=%b data=%h want 1/%h", j, rd_bus.rd_valid, rd_bus.rd_data, ev);
      end
    end
    rd_bus.rd_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] ev;
    arm = 1'b1; stop = 1'b1; mode = 1'b0;
    tick();
    arm = 1'b0; stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || capture_done !== 1'b0 || wr_addr !== 4'd0 || wrapped !== 1'b0) begin
      n_fail++; $display("FAIL arm_stop_in_done: busy=%b done=%b wr_addr=%0d wrapped=%b want 1/0/0/0", busy, capture_done, wr_addr, wrapped);
    end
    channel_data = pat(8'hE0); sample_valid = 1'b1; stop = 1'b1;
    tick();
    sample_valid = 1'b0; stop = 1'b0;
    n_cmp++;
    if (capture_done !== 1'b1 || wr_addr !== 4'd0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL stop_sv_in_capture: done=%b wr_addr=%0d ovr=%b want 1/0/0", capture_done, wr_addr, overrun);
    end
    repeat (7) tick();
    for (int j = 0; j < 3; j++) begin
      read_req(0, j);
      tick();
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== ev) begin
        n_fail++; $display("FAIL dropped_read%0d: valid=%b data=%h want 1/%h", j, rd_bus.rd_valid, rd_bus.rd_data, ev);
      end
    end
    rd_bus.rd_en = 1'b0;
  endtask

  task automatic test_stop_in_write();
    int cnt;
    logic [7:0] ev;
    do_arm(1'b1);
    put_sample(0, pat(8'h60));
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cnt = 3;
    while (capture_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != 7 || wr_addr !== 4'd1) begin
      n_fail++; $display("FAIL stop_in_write: done at %0d wr_addr=%0d want 7/1", cnt, wr_addr);
    end
    for (int j = 0; j < NUM_CH; j++) begin
      read_req(0, j);
      tick();
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== ev) begin
        n_fail++; $display("FAIL stopw_read%0d: valid=%b data=%h want 1/%h", j, rd_bus.rd_valid, rd_bus.rd_data, ev);
      end
    end
    rd_bus.rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [16:0] st;
    logic [7:0]  ev;
    do_arm(1'b0);
    put_sample(0, pat(8'h30));
    repeat (7) tick();
    put_sample(-1, pat(8'h38));
    repeat (2) tick();
    #2;
    reset_reset_n = 1'b0;
    #1;
    st = {wr_addr, capture_done, busy, wrapped, overrun, rd_bus.rd_data, rd_bus.rd_valid};
    n_cmp++;
    if (st !== 17'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want 00000", st);
    end
    repeat (2) tick();
    reset_reset_n = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || capture_done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_mid_reset: busy=%b done=%b want 0/0", busy, capture_done);
    end
    do_arm(1'b0);
    put_sample(0, pat(8'h48));
    repeat (7) tick();
    n_cmp++;
    if (wr_addr !== 4'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rearm_after_reset: wr_addr=%0d busy=%b want 1/1", wr_addr, busy);
    end
    for (int j = 0; j < NUM_CH; j++) begin
      read_req(0, j);
      tick();
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== ev) begin
        n_fail++; $display("FAIL rearm_read%0d: valid=%b data=%h want 1/%h", j, rd_bus.rd_valid, rd_bus.rd_data, ev);
      end
    end
    rd_bus.rd_en = 1'b0;
  endtask

  initial begin
    rd_bus.rd_en   = 1'b0;
    rd_bus.rd_addr = '0;
    rd_bus.rd_ch   = '0;
    test_reset();
    test_single_fill();
    test_overrun();
    test_continuous();
    test_simultaneous();
    test_stop_in_write();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
